// File: rtl/half_sub.sv
// -----------------------------------------------------------------------------
// half_sub
//
// Registered 1-bit half subtractor replicated across LANES independent lanes.
// Each lane computes difference D = a ^ b and borrow B = ~a & b. Results are
// registered with a one-cycle latency and qualified by out_valid.
//
// Parameters:
//   LANES  number of independent 1-bit subtractor lanes (>= 1)
//   CNT_W  width of the optional borrow event counter (>= 1)
//
// Ports:
//   clk        in   1      sole clock, rising edge
//   rst        in   1      synchronous active-high reset
//   a          in   LANES  minuend bits
//   b          in   LANES  subtrahend bits
//   in_valid   in   1      a/b accepted this cycle when high
//   D          out  LANES  registered difference
//   B          out  LANES  registered borrow
//   out_valid  out  1      high one cycle after an accepted input
//   borrow_cnt out  CNT_W  saturating count of borrow events
//                          (present only when HALF_SUB_BORROW_CNT_EN is defined)
//
// Build option:
//   HALF_SUB_BORROW_CNT_EN  adds borrow_cnt, which accumulates popcount(~a & b)
//                           on every accepted input and saturates at all-ones.
// -----------------------------------------------------------------------------
module half_sub #(
    parameter int LANES = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANES-1:0] a,
    input  logic [LANES-1:0] b,
    input  logic             in_valid,
    output logic [LANES-1:0] D,
    output logic [LANES-1:0] B,
    output logic             out_valid
`ifdef HALF_SUB_BORROW_CNT_EN
    ,
    output logic [CNT_W-1:0] borrow_cnt
`endif
);

    logic [LANES-1:0] w_d_p0;
    logic [LANES-1:0] w_b_p0;
    logic [LANES-1:0] r_d_p1;
    logic [LANES-1:0] r_b_p1;
    logic             r_vld_p1;

    assign w_d_p0 = a ^ b;
    assign w_b_p0 = ~a & b;

    // ---- stage p0 -> p1: register lane results and valid ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_d_p1   <= '0;
            r_b_p1   <= '0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_d_p1 <= w_d_p0;
                r_b_p1 <= w_b_p0;
            end
        end
    end

    assign D         = r_d_p1;
    assign B         = r_b_p1;
    assign out_valid = r_vld_p1;

`ifdef HALF_SUB_BORROW_CNT_EN
    localparam int PC_W  = $clog2(LANES + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

    function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // Sum is formed one bit wider than either operand so overflow is
    // visible and can be clamped instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                                 input logic [PC_W-1:0]  inc);
        logic [SUM_W-1:0] s;
        logic [SUM_W-1:0] lim;
        s   = SUM_W'(c) + SUM_W'(inc);
        lim = SUM_W'({CNT_W{1'b1}});
        if (s > lim) begin
            return {CNT_W{1'b1}};
        end
        return s[CNT_W-1:0];
    endfunction

    logic [CNT_W-1:0] r_cnt_p1;

    // ---- stage p0 -> p1: borrow event accumulation ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_p1 <= '0;
        end else if (in_valid) begin
            r_cnt_p1 <= sat_add(r_cnt_p1, popcount(w_b_p0));
        end
    end

    assign borrow_cnt = r_cnt_p1;
`endif

endmodule

// File: tb/tb_half_sub.sv
module tb_half_sub;

    logic clk = 1'b0;
    logic rst;

    logic [0:0] a1, b1;
    logic       v1;
    logic [0:0] d1_o, b1_o;
    logic       ov1;

    logic [3:0] a4, b4;
    logic       v4;
    logic [3:0] d4_o, b4_o;
    logic       ov4;

`ifdef HALF_SUB_BORROW_CNT_EN
    logic [1:0] cnt1_o;
    logic [7:0] cnt4_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    logic [3:0] m1_d, m1_b, m4_d, m4_b;
    logic       m1_v, m4_v;
    int         m1_cnt, m4_cnt;

    always #5 clk = ~clk;

    half_sub #(.LANES(1), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1),
        .D(d1_o), .B(b1_o), .out_valid(ov1)
`ifdef HALF_SUB_BORROW_CNT_EN
        , .borrow_cnt(cnt1_o)
`endif
    );

    half_sub #(.LANES(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(v4),
        .D(d4_o), .B(b4_o), .out_valid(ov4)
`ifdef HALF_SUB_BORROW_CNT_EN
        , .borrow_cnt(cnt4_o)
`endif
    );

    // Per-lane integer subtraction: difference is the result modulo 2,
    // borrow is whether the minuend was smaller than the subtrahend.
    task automatic model_sub(input logic [3:0] a, input logic [3:0] b, input int lanes,
                             output logic [3:0] d, output logic [3:0] bo, output int nb);
        d = '0; bo = '0; nb = 0;
        for (int i = 0; i < lanes; i++) begin
            int diff;
            diff = int'(a[i]) - int'(b[i]);
            d[i]  = (diff != 0);
            bo[i] = (diff < 0);
            if (diff < 0) nb++;
        end
    endtask

    task automatic tick();
        logic [3:0] d, bo;
        int nb;
        @(posedge clk);
        if (rst) begin
            m1_d = 0; m1_b = 0; m1_v = 0; m1_cnt = 0;
            m4_d = 0; m4_b = 0; m4_v = 0; m4_cnt = 0;
        end else begin
            m1_v = v1;
            if (v1) begin
                model_sub({3'b0, a1}, {3'b0, b1}, 1, d, bo, nb);
                m1_d = d; m1_b = bo;
                m1_cnt = (m1_cnt + nb > 3) ? 3 : m1_cnt + nb;
            end
            m4_v = v4;
            if (v4) begin
                model_sub(a4, b4, 4, d, bo, nb);
                m4_d = d; m4_b = bo;
                m4_cnt = (m4_cnt + nb > 255) ? 255 : m4_cnt + nb;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        v1 = 0; a1 = 0; b1 = 0;
        v4 = 0; a4 = 0; b4 = 0;
    endtask

    task automatic test_reset();
        rst = 1; v1 = 1; a1 = 0; b1 = 1; v4 = 1; a4 = 4'h0; b4 = 4'hF;
        tick();
        n_vec++;
        if ({d1_o, b1_o, ov1} !== 3'b000) begin
            $display("FAIL reset_dut1 got D=%b B=%b V=%b want 0 0 0", d1_o, b1_o, ov1); n_err++;
        end
        n_vec++;
        if ({d4_o, b4_o, ov4} !== 9'b0) begin
            $display("FAIL reset_dut4 got D=%b B=%b V=%b want 0 0 0", d4_o, b4_o, ov4); n_err++;
        end
`ifdef HALF_SUB_BORROW_CNT_EN
        n_vec++;
        if (cnt1_o !== 2'd0 || cnt4_o !== 8'd0) begin
            $display("FAIL reset_cnt got %0d/%0d want 0/0", cnt1_o, cnt4_o); n_err++;
        end
`endif
        rst = 0; idle_inputs();
    endtask

    task automatic test_truth_table();
        logic [1:0] exp [4];
        exp[0] = 2'b00; exp[1] = 2'b11; exp[2] = 2'b10; exp[3] = 2'b00;
        for (int k = 0; k < 4; k++) begin
            v1 = 1; a1 = k[1]; b1 = k[0];
            tick();
            n_vec++;
            if ({d1_o, b1_o} !== exp[k] || ov1 !== 1'b1) begin
                $display("FAIL truth_ab%0d%0d got DB=%b%b V=%b want %b V=1",
                         k[1], k[0], d1_o, b1_o, ov1, exp[k]); n_err++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_hold();
        logic [2:0] exp_v;
        v1 = 1; a1 = 1; b1 = 0;
        tick();
        exp_v = 3'b000;
        n_vec++;
        if ({d1_o, b1_o, ov1} !== 3'b101) begin
            $display("FAIL hold_load got D=%b B=%b V=%b want 1 0 1", d1_o, b1_o, ov1); n_err++;
        end
        // drive a different pattern with valid low; it must be ignored
        v1 = 0; a1 = 0; b1 = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if ({d1_o, b1_o, ov1} !== {2'b10, exp_v[k]}) begin
                $display("FAIL hold_cycle%0d got D=%b B=%b V=%b want 1 0 0", k, d1_o, b1_o, ov1); n_err++;
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midstream();
        v1 = 1; a1 = 0; b1 = 1;
        tick();
        n_vec++;
        if ({d1_o, b1_o, ov1} !== 3'b111) begin
            $display("FAIL mid_preload got D=%b B=%b V=%b want 1 1 1", d1_o, b1_o, ov1); n_err++;
        end
        rst = 1;
        tick();
        rst = 0; idle_inputs();
        n_vec++;
        if ({d1_o, b1_o, ov1} !== 3'b000) begin
            $display("FAIL mid_reset got D=%b B=%b V=%b want 0 0 0", d1_o, b1_o, ov1); n_err++;
        end
`ifdef HALF_SUB_BORROW_CNT_EN
        n_vec++;
        if (cnt1_o !== 2'd0) begin
            $display("FAIL mid_reset_cnt got %0d want 0", cnt1_o); n_err++;
        end
`endif
        tick();
        n_vec++;
        if (ov1 !== 1'b0) begin
            $display("FAIL mid_after got V=%b want 0", ov1); n_err++;
        end
    endtask

    task automatic test_lanes4();
        v4 = 1; a4 = 4'b0101; b4 = 4'b0011;
        tick();
        n_vec++;
        if (d4_o !== 4'b0110 || b4_o !== 4'b0010 || ov4 !== 1'b1) begin
            $display("FAIL lanes4 got D=%b B=%b V=%b want 0110 0010 1", d4_o, b4_o, ov4); n_err++;
        end
        a4 = 4'b0000; b4 = 4'b1111;
        tick();
        n_vec++;
        if (d4_o !== 4'b1111 || b4_o !== 4'b1111) begin
            $display("FAIL lanes4_all got D=%b B=%b want 1111 1111", d4_o, b4_o); n_err++;
        end
        idle_inputs();
    endtask

`ifdef HALF_SUB_BORROW_CNT_EN
    task automatic test_borrow_sat();
        int exp [5];
        exp[0] = 1; exp[1] = 2; exp[2] = 3; exp[3] = 3; exp[4] = 3;
        rst = 1; tick(); rst = 0;
        for (int k = 0; k < 5; k++) begin
            v1 = 1; a1 = 0; b1 = 1;
            tick();
            n_vec++;
            if (int'(cnt1_o) !== exp[k]) begin
                $display("FAIL borrow_sat%0d got %0d want %0d", k, cnt1_o, exp[k]); n_err++;
            end
        end
        idle_inputs();
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 1000; k++) begin
            rst = ($urandom_range(0, 49) == 0);
            v1 = $urandom_range(0, 3) != 0; a1 = 1'($urandom); b1 = 1'($urandom);
            v4 = $urandom_range(0, 3) != 0; a4 = 4'($urandom); b4 = 4'($urandom);
            tick();
            n_vec++;
            if (d1_o !== m1_d[0] || b1_o !== m1_b[0] || ov1 !== m1_v ||
                d4_o !== m4_d || b4_o !== m4_b || ov4 !== m4_v) begin
                $display("FAIL random%0d got %b%b%b/%b %b %b want %b%b%b/%b %b %b", k,
                         d1_o, b1_o, ov1, d4_o, b4_o, ov4,
                         m1_d[0], m1_b[0], m1_v, m4_d, m4_b, m4_v); n_err++;
            end
`ifdef HALF_SUB_BORROW_CNT_EN
            n_vec++;
            if (int'(cnt1_o) !== m1_cnt || int'(cnt4_o) !== m4_cnt) begin
                $display("FAIL random_cnt%0d got %0d/%0d want %0d/%0d", k,
                         cnt1_o, cnt4_o, m1_cnt, m4_cnt); n_err++;
            end
`endif
        end
        rst = 0; idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 0;
        idle_inputs();
        m1_d = 0; m1_b = 0; m1_v = 0; m1_cnt = 0;
        m4_d = 0; m4_b = 0; m4_v = 0; m4_cnt = 0;
        #1;
        test_reset();
        test_truth_table();
        test_hold();
        test_reset_midstream();
        test_lanes4();
`ifdef HALF_SUB_BORROW_CNT_EN
        test_borrow_sat();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
